popcount_window_stats: RTL and testbench
========================================

POPCOUNT_WINDOW_STATS -- requirements
Module: popcount_window_stats

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of the words whose popcounts arrive; cnt_i range is 0..WIDTH.
REQ-002 SHALL have parameter WINDOW, default 16: number of valid samples per statistics window; legal values are WINDOW >= 2.
REQ-003 SHALL have port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port cnt_i  input  CNT_W=$clog2(WIDTH)+1: popcount sample.
REQ-006 SHALL have port cnt_val_i  input  1: cnt_i valid this cycle; no backpressure.
REQ-007 SHALL have port flush_i  input  1: close the current window early.
REQ-008 SHALL have port sum_o  output  SUM_W=$clog2(WIDTH*WINDOW+1): sum of the window's samples.
REQ-009 SHALL have port min_o  output  CNT_W: smallest sample in the window.
REQ-010 SHALL have port max_o  output  CNT_W: largest sample in the window.
REQ-011 SHALL have port samples_o  output  SAMP_W=$clog2(WINDOW+1): sample count of the closed window.
REQ-012 SHALL have port stats_val_o  output  1: one-cycle pulse; sum_o, min_o, max_o and samples_o are valid.

Function
REQ-013 SHALL accept a sample on every cycle with cnt_val_i=1, with no dead cycles, including the cycle immediately after a window closes.
REQ-014 SHALL have FSM states EMPTY (0 samples accumulated) and ACCUM (1..WINDOW-1 samples accumulated).
REQ-015 SHALL transition EMPTY->ACCUM on an accepted sample that does not close the window.
REQ-016 SHALL transition ACCUM->EMPTY on window close.
REQ-017 SHALL close the window in the cycle where the accepted sample makes the count equal WINDOW.
REQ-018 SHALL also close the window when flush_i=1 and the window, including any sample accepted that cycle, holds at least 1 sample.
REQ-019 SHALL include the sample in the closing window when cnt_val_i and flush_i are both 1 in the same cycle.
REQ-020 SHALL ignore flush_i on an empty window: no stats_val_o pulse, no state change.
REQ-021 SHALL assert stats_val_o exactly one cycle after the closing cycle, as a registered output.
REQ-022 SHALL hold sum_o, min_o, max_o and samples_o stable from that pulse until the next stats_val_o pulse.
REQ-023 SHALL seed the running min with WIDTH and the running max with 0 at each window start.
REQ-024 SHALL update both the running min and max using the incoming sample in the same cycle.
REQ-025 SHALL compute the sum in full SUM_W width, which cannot overflow.
REQ-026 SHALL start the next window from the seed values after a close; accumulators are not double-counted.
REQ-027 SHALL NOT respond to flush_i when the window reaches WINDOW in the same cycle; that cycle produces a single close.
REQ-028 SHALL ignore cnt_i when cnt_val_i=0.

Reset
REQ-029 SHALL, while rst_n_i=0, drive every output to 0 (sum_o, min_o, max_o, samples_o, stats_val_o), put the FSM in EMPTY, zero the sample counter and sum, set the running min to WIDTH and the running max to 0.
REQ-030 SHALL discard a partial window in progress when reset asserts; no stats_val_o pulse is produced for it.
REQ-031 SHALL accept a sample on the first rising edge after rst_n_i deasserts.

Structure
REQ-032 SHALL take the CNT_W, SUM_W and SAMP_W width functions and the FSM state enum from the shared package popcount_pkg.
REQ-033 SHALL use sub-module popcount_minmax, which holds the running min/max registers, clear and update.
REQ-034 SHALL keep the sum, counter, FSM and output registers in the top level.

Verification (WIDTH=8, WINDOW=4)
REQ-035 SHALL test a full window: samples 3,5,0,8 on 4 consecutive cycles -> one cycle after the 4th, stats_val_o=1 with sum=16, min=0, max=8, samples=4.
REQ-036 SHALL test early flush: samples 7,1, then flush_i alone -> stats_val_o with sum=8, min=1, max=7, samples=2.
REQ-037 SHALL test simultaneous sample and flush: sample 6 with flush_i=1 on an empty window -> sum=6, min=6, max=6, samples=1; flush_i alone on the empty window -> no pulse.
REQ-038 SHALL test back-to-back windows: 8 consecutive samples of value 2 -> exactly two pulses 4 cycles apart, each with sum=8, min=2, max=2.
REQ-039 SHALL test reset mid-window: samples 4,4, then rst_n_i low for 2 cycles -> all outputs 0 immediately; after release, samples 1,1,1,1 -> sum=4, samples=4.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared widths and FSM state encoding for the popcount window statistics block.
package popcount_pkg;

    // Window accumulation state: EMPTY holds no samples, ACCUM holds 1..WINDOW-1.
    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Width of one popcount sample (0..width inclusive).
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // Width of a full-window sum; sized so the largest possible sum always fits.
    function automatic int sum_w(input int width, input int window);
        return $clog2(width * window + 1);
    endfunction

    // Width of the per-window sample counter (0..window inclusive).
    function automatic int samp_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/popcount_window_stats_if.sv
// Bundle of the sample input and statistics output of popcount_window_stats.
interface popcount_window_stats_if
    import popcount_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 16
);
    localparam int CNT_W  = cnt_w(WIDTH);
    localparam int SUM_W  = sum_w(WIDTH, WINDOW);
    localparam int SAMP_W = samp_w(WINDOW);

    logic [CNT_W-1:0]  cnt;
    logic              cnt_val;
    logic              flush;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  min_v;
    logic [CNT_W-1:0]  max_v;
    logic [SAMP_W-1:0] samples;
    logic              stats_val;

    // Sample producer side.
    modport master (
        output cnt, cnt_val, flush,
        input  sum, min_v, max_v, samples, stats_val
    );

    // Statistics engine side.
    modport slave (
        input  cnt, cnt_val, flush,
        output sum, min_v, max_v, samples, stats_val
    );

endinterface

// File: rtl/popcount_minmax.sv
// Running min/max tracker for one statistics window. The *_nxt outputs already
// include the current sample so the closing cycle can report them directly.
module popcount_minmax
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             upd,
    input  logic [CNT_W-1:0] sample,
    output logic [CNT_W-1:0] run_min,
    output logic [CNT_W-1:0] run_max,
    output logic [CNT_W-1:0] min_nxt,
    output logic [CNT_W-1:0] max_nxt
);

    localparam logic [CNT_W-1:0] MIN_SEED = CNT_W'(WIDTH);

    // Fold the incoming sample into both extremes in the same cycle.
    always_comb begin
        min_nxt = run_min;
        max_nxt = run_max;
        if (upd && (sample < run_min)) min_nxt = sample;
        if (upd && (sample > run_max)) max_nxt = sample;
    end

    // Hold the running extremes; a window close reseeds them for the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min <= MIN_SEED;
            run_max <= '0;
        end else if (clr) begin
            run_min <= MIN_SEED;
            run_max <= '0;
        end else begin
            run_min <= min_nxt;
            run_max <= max_nxt;
        end
    end

endmodule

// File: rtl/popcount_window_stats.sv
// Windowed statistics (sum/min/max/count) over a stream of popcount samples.
// A window closes when it reaches WINDOW samples or on flush of a non-empty
// window; results appear as a registered one-cycle pulse the cycle after.
module popcount_window_stats
    import popcount_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 16,
    localparam int CNT_W  = cnt_w(WIDTH),
    localparam int SUM_W  = sum_w(WIDTH, WINDOW),
    localparam int SAMP_W = samp_w(WINDOW)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              cnt_val_i,
    input  logic              flush_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  min_o,
    output logic [CNT_W-1:0]  max_o,
    output logic [SAMP_W-1:0] samples_o,
    output logic              stats_val_o
);

    localparam logic [SAMP_W-1:0] WIN_CNT = SAMP_W'(WINDOW);

    state_t            state, state_nxt;
    logic [SAMP_W-1:0] count;
    logic [SAMP_W-1:0] count_nxt;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_nxt;
    logic              full;
    logic              close;
    logic [CNT_W-1:0]  run_min, run_max;
    logic [CNT_W-1:0]  min_nxt, max_nxt;

    // Window bookkeeping including this cycle's sample; cnt_i is masked when not valid.
    // A full window takes priority, so a simultaneous flush adds no second close.
    always_comb begin
        count_nxt = count + SAMP_W'(cnt_val_i);
        sum_nxt   = sum_q + (cnt_val_i ? SUM_W'(cnt_i) : '0);
        full      = cnt_val_i && (count_nxt == WIN_CNT);
        close     = full || (flush_i && ((state == ACCUM) || cnt_val_i));
    end

    // Next state: any close empties the window, an accepted sample otherwise fills it.
    always_comb begin
        state_nxt = state;
        if (close)          state_nxt = EMPTY;
        else if (cnt_val_i) state_nxt = ACCUM;
    end

    // FSM, sample counter and running sum; accumulators restart from zero on close.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= EMPTY;
            count <= '0;
            sum_q <= '0;
        end else begin
            state <= state_nxt;
            count <= close ? '0 : count_nxt;
            sum_q <= close ? '0 : sum_nxt;
        end
    end

    popcount_minmax #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_minmax (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .clr     (close),
        .upd     (cnt_val_i),
        .sample  (cnt_i),
        .run_min (run_min),
        .run_max (run_max),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt)
    );

    // Capture the closed window's results; they hold until the next close.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_o       <= '0;
            min_o       <= '0;
            max_o       <= '0;
            samples_o   <= '0;
            stats_val_o <= 1'b0;
        end else begin
            stats_val_o <= close;
            if (close) begin
                sum_o     <= sum_nxt;
                min_o     <= min_nxt;
                max_o     <= max_nxt;
                samples_o <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Directed bench for popcount_window_stats (WIDTH=8, WINDOW=4). Stimulus pushes
// the expected result and pulse cycle into a queue; a monitor checks every cycle.
module tb_popcount_window_stats;
    import popcount_pkg::*;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 4;

    typedef struct {
        int sum;
        int mn;
        int mx;
        int smp;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    popcount_window_stats_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

    popcount_window_stats #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cnt_i       (bus.cnt),
        .cnt_val_i   (bus.cnt_val),
        .flush_i     (bus.flush),
        .sum_o       (bus.sum),
        .min_o       (bus.min_v),
        .max_o       (bus.max_v),
        .samples_o   (bus.samples),
        .stats_val_o (bus.stats_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Drive one cycle of stimulus; if a window closes here, expect its pulse next cycle.
    task automatic drive(input int c, input bit v, input bit f,
                         input bit e, input int es, input int en, input int ex, input int ec);
        exp_t x;
        bus.cnt     = 4'(c);
        bus.cnt_val = v;
        bus.flush   = f;
        if (e) begin
            x.sum = es; x.mn = en; x.mx = ex; x.smp = ec; x.cyc = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input int c);
        drive(c, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: pulse presence/timing every cycle, result fields on a pulse,
    // and result stability between pulses.
    int last_sum, last_mn, last_mx, last_smp;
    always @(negedge clk) begin
        bit   exp_p;
        exp_t e;
        if (!rst_n) begin
            last_sum = 0; last_mn = 0; last_mx = 0; last_smp = 0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse got none expected pulse at cycle %0d", e.cyc);
            end
            exp_p = (q.size() > 0) && (q[0].cyc == cyc);
            chk("stats_val", int'(bus.stats_val), int'(exp_p));
            if (bus.stats_val && exp_p) begin
                e = q.pop_front();
                chk("sum", int'(bus.sum), e.sum);
                chk("min", int'(bus.min_v), e.mn);
                chk("max", int'(bus.max_v), e.mx);
                chk("samples", int'(bus.samples), e.smp);
            end else if (!bus.stats_val) begin
                chk("hold_sum", int'(bus.sum), last_sum);
                chk("hold_min", int'(bus.min_v), last_mn);
                chk("hold_max", int'(bus.max_v), last_mx);
                chk("hold_samples", int'(bus.samples), last_smp);
            end
            last_sum = int'(bus.sum);
            last_mn  = int'(bus.min_v);
            last_mx  = int'(bus.max_v);
            last_smp = int'(bus.samples);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_sum"}, int'(bus.sum), 0);
        chk({tag, "_min"}, int'(bus.min_v), 0);
        chk({tag, "_max"}, int'(bus.max_v), 0);
        chk({tag, "_samples"}, int'(bus.samples), 0);
        chk({tag, "_val"}, int'(bus.stats_val), 0);
    endtask

    initial begin
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.cnt     = '0;
        bus.cnt_val = 1'b0;
        bus.flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Full window: 3,5,0,8 -> sum 16, min 0, max 8.
        samp(3); samp(5); samp(0);
        drive(8, 1'b1, 1'b0, 1'b1, 16, 0, 8, 4);
        idle(2);

        // Early flush after 7,1.
        samp(7); samp(1);
        drive(0, 1'b0, 1'b1, 1'b1, 8, 1, 7, 2);
        idle(2);

        // Sample with flush on an empty window, then flush alone on empty (no pulse).
        drive(6, 1'b1, 1'b1, 1'b1, 6, 6, 6, 1);
        drive(0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(3);

        // Back-to-back windows of 2s, no gap between them.
        for (int w = 0; w < 2; w++) begin
            samp(2); samp(2); samp(2);
            drive(2, 1'b1, 1'b0, 1'b1, 8, 2, 2, 4);
        end
        idle(2);

        // Flush coinciding with the filling sample gives one close; following flush is ignored.
        samp(1); samp(2); samp(3);
        drive(4, 1'b1, 1'b1, 1'b1, 10, 1, 4, 4);
        drive(0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(2);

        // Invalid cycles with a large cnt_i must not contribute.
        samp(5);
        drive(8, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        drive(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        samp(5);
        drive(8, 1'b0, 1'b1, 1'b1, 10, 5, 5, 2);
        idle(2);

        // Reset mid-window: partial window discarded, outputs cleared at once.
        samp(4); samp(4);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        samp(1); samp(1); samp(1);
        drive(1, 1'b1, 1'b0, 1'b1, 4, 1, 1, 4);
        idle(4);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
